// File: rtl/nn_pkg.sv
// Shared types and pixel-to-fixed-point conversion for the network input loader.
// Optional macro NN_IN_CENTER_EN centres converted pixels around zero.
package nn_pkg;

    localparam int NN_DATA_WIDTH = 16;
    localparam int NN_FRAC_BITS  = 11;

    typedef logic [NN_DATA_WIDTH-1:0] fx_t;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        FULL = 1'b1
    } loader_state_t;

    // Aligns an unsigned pixel's binary point to the fixed-point fraction.
    function automatic logic [31:0] fx_align(input logic [31:0] pix,
                                             input int pix_w,
                                             input int frac);
        if (frac >= pix_w) begin
            return pix << (frac - pix_w);
        end
        return pix >> (pix_w - frac);
    endfunction

    // The result is wide; callers truncate to the word width, which also
    // sign-extends the centred value correctly in two's complement.
    function automatic logic [31:0] pixel_to_fx(input logic [31:0] pix,
                                                input int pix_w,
                                                input int frac);
        logic [31:0] q;
`ifdef NN_IN_CENTER_EN
        logic [31:0] full_scale;
`endif
        q = fx_align(pix, pix_w, frac);
`ifdef NN_IN_CENTER_EN
        full_scale = fx_align((32'd1 << pix_w) - 32'd1, pix_w, frac);
        q = q - (full_scale >> 1);
`endif
        return q;
    endfunction

endpackage

// File: rtl/nn_pixel_quant.sv
// Combinational conversion of one unsigned pixel into the network's fixed-point word.
// Centring is enabled by NN_IN_CENTER_EN through the package function.
module nn_pixel_quant
    import nn_pkg::*;
#(
    parameter int PIXEL_WIDTH = 8,
    parameter int FRAC_BITS   = NN_FRAC_BITS,
    parameter int DATA_WIDTH  = NN_DATA_WIDTH
)(
    input  logic [PIXEL_WIDTH-1:0] i_pixel,
    output logic [DATA_WIDTH-1:0]  o_fx
);

    assign o_fx = DATA_WIDTH'(pixel_to_fx(32'(i_pixel), PIXEL_WIDTH, FRAC_BITS));

endmodule

// File: rtl/nn_input_loader.sv
// Packs a pixel stream into frames and launches each frame to the network when it is idle.
// Build macro NN_IN_CENTER_EN selects zero-centred conversion.
module nn_input_loader
    import nn_pkg::*;
#(
    parameter int NUM_INPUTS  = 4,
    parameter int DATA_WIDTH  = NN_DATA_WIDTH,
    parameter int FRAC_BITS   = NN_FRAC_BITS,
    parameter int PIXEL_WIDTH = 8
)(
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [PIXEL_WIDTH-1:0]           s_data,
    input  logic                             s_last,
    input  logic                             net_done,
    output logic [NUM_INPUTS*DATA_WIDTH-1:0] in_vec,
    output logic                             first,
    output logic                             net_busy,
    output logic                             err_len,
    output logic [15:0]                      frame_cnt
);

    localparam int CNT_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int VEC_W = NUM_INPUTS * DATA_WIDTH;

    loader_state_t           r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [VEC_W-1:0]        r_shadow;
    logic [VEC_W-1:0]        r_in_vec;
    logic                    r_first;
    logic                    r_busy;
    logic                    r_err;
    logic [15:0]             r_frame_cnt;

    logic [DATA_WIDTH-1:0]   w_fx;
    logic                    w_accept;
    logic                    w_last_beat;
    logic                    w_launch;

    nn_pixel_quant #(
        .PIXEL_WIDTH (PIXEL_WIDTH),
        .FRAC_BITS   (FRAC_BITS),
        .DATA_WIDTH  (DATA_WIDTH)
    ) u_quant (
        .i_pixel (s_data),
        .o_fx    (w_fx)
    );

    assign w_accept    = s_valid && (r_state == FILL);
    assign w_last_beat = (r_cnt == CNT_W'(NUM_INPUTS - 1));
    // A finishing network frees the slot in the same cycle, allowing back-to-back frames.
    assign w_launch    = (r_state == FULL) && (!r_busy || net_done);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= FILL;
            r_cnt       <= '0;
            r_shadow    <= '0;
            r_in_vec    <= '0;
            r_first     <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_first <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                FILL: begin
                    if (w_accept) begin
                        r_shadow[r_cnt*DATA_WIDTH +: DATA_WIDTH] <= w_fx;
                        if (w_last_beat) begin
                            r_state <= FULL;
                        end else if (s_last) begin
                            r_cnt <= '0;
                            r_err <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (w_launch) begin
                        r_in_vec    <= r_shadow;
                        r_first     <= 1'b1;
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                        r_cnt       <= '0;
                        r_state     <= FILL;
                    end
                end
                default: r_state <= FILL;
            endcase

            if (w_launch) begin
                r_busy <= 1'b1;
            end else if (net_done) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign s_ready   = (r_state == FILL);
    assign in_vec    = r_in_vec;
    assign first     = r_first;
    assign net_busy  = r_busy;
    assign err_len   = r_err;
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_nn_input_loader.sv
// Directed bench for nn_input_loader with default parameters (4 x 16-bit, 11 fraction bits).
// Expected words follow NN_IN_CENTER_EN when the bench is built with it.
module tb_nn_input_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        s_last;
    logic        net_done;
    logic [63:0] in_vec;
    logic        first;
    logic        net_busy;
    logic        err_len;
    logic [15:0] frame_cnt;

    int n_total = 0;
    int n_bad   = 0;

    nn_input_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .net_done  (net_done),
        .in_vec    (in_vec),
        .first     (first),
        .net_busy  (net_busy),
        .err_len   (err_len),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_fx(input int p);
`ifdef NN_IN_CENTER_EN
        return 16'(p * 8 - 1020);
`else
        return 16'(p * 8);
`endif
    endfunction

    // Called at a falling edge; the beat is presented across the next rising edge.
    task automatic beat(input logic [7:0] d, input logic l);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic done_pulse();
        net_done = 1'b1;
        @(negedge clk);
        net_done = 1'b0;
    endtask

    logic [63:0] frame1_vec;
    logic        pat_v [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [7:0]  pat_d [7] = '{8'd2, 8'd0, 8'd0, 8'd3, 8'd4, 8'd0, 8'd6};

    initial begin
`ifdef NN_IN_CENTER_EN
        frame1_vec = 64'hFC0C_0004_03FC_FC04;
`else
        frame1_vec = 64'h0008_0400_07F8_0000;
`endif
        rst_n    = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        s_last   = 1'b0;
        net_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_vec", in_vec, 64'h0);
        chk("rst_first", {63'h0, first}, 64'h0);
        chk("rst_busy", {63'h0, net_busy}, 64'h0);
        chk("rst_err", {63'h0, err_len}, 64'h0);
        chk("rst_cnt", {48'h0, frame_cnt}, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", {63'h0, s_ready}, 64'h1);

        // Frame 1 into an idle network
        beat(8'd0, 1'b0);
        beat(8'd255, 1'b0);
        beat(8'd128, 1'b0);
        beat(8'd1, 1'b1);
        chk("f1_ready_low", {63'h0, s_ready}, 64'h0);
        chk("f1_first_early", {63'h0, first}, 64'h0);
        @(negedge clk);
        chk("f1_first", {63'h0, first}, 64'h1);
        chk("f1_vec", in_vec, frame1_vec);
        chk("f1_busy", {63'h0, net_busy}, 64'h1);
        chk("f1_cnt", {48'h0, frame_cnt}, 64'd1);
        @(negedge clk);
        chk("f1_first_once", {63'h0, first}, 64'h0);

        // Frame 2 fills while the network is busy
        beat(8'd10, 1'b0);
        beat(8'd20, 1'b0);
        beat(8'd30, 1'b0);
        beat(8'd40, 1'b0);
        chk("f2_ready_low", {63'h0, s_ready}, 64'h0);
        repeat (2) begin
            @(negedge clk);
            chk("f2_no_first", {63'h0, first}, 64'h0);
            chk("f2_vec_hold", in_vec, frame1_vec);
        end
        done_pulse();
        chk("f2_first", {63'h0, first}, 64'h1);
        chk("f2_vec", in_vec, {exp_fx(40), exp_fx(30), exp_fx(20), exp_fx(10)});
        chk("f2_busy", {63'h0, net_busy}, 64'h1);
        chk("f2_cnt", {48'h0, frame_cnt}, 64'd2);
        done_pulse();
        chk("f2_busy_clr", {63'h0, net_busy}, 64'h0);
        chk("f2_first_once", {63'h0, first}, 64'h0);

        // Short frame discarded, then a clean frame
        beat(8'd5, 1'b0);
        beat(8'd6, 1'b1);
        chk("short_err", {63'h0, err_len}, 64'h1);
        chk("short_ready", {63'h0, s_ready}, 64'h1);
        chk("short_no_first", {63'h0, first}, 64'h0);
        beat(8'd7, 1'b0);
        chk("short_err_once", {63'h0, err_len}, 64'h0);
        beat(8'd8, 1'b0);
        beat(8'd9, 1'b0);
        beat(8'd11, 1'b1);
        @(negedge clk);
        chk("f3_first", {63'h0, first}, 64'h1);
        chk("f3_vec", in_vec, {exp_fx(11), exp_fx(9), exp_fx(8), exp_fx(7)});
        chk("f3_cnt", {48'h0, frame_cnt}, 64'd3);
        chk("f3_err_quiet", {63'h0, err_len}, 64'h0);
        done_pulse();

        // Gapped valid: 1,0,0,1,1,0,1
        for (int i = 0; i < 7; i++) begin
            s_valid = pat_v[i];
            s_data  = pat_d[i];
            @(negedge clk);
        end
        s_valid = 1'b0;
        chk("gap_first_n1", {63'h0, first}, 64'h0);
        chk("gap_ready_low", {63'h0, s_ready}, 64'h0);
        @(negedge clk);
        chk("gap_first_n2", {63'h0, first}, 64'h1);
        chk("gap_vec", in_vec, {exp_fx(6), exp_fx(4), exp_fx(3), exp_fx(2)});
        chk("gap_cnt", {48'h0, frame_cnt}, 64'd4);

        // Asynchronous reset mid-frame while a frame is in flight
        beat(8'd50, 1'b0);
        beat(8'd60, 1'b0);
        chk("pre_rst_busy", {63'h0, net_busy}, 64'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_vec", in_vec, 64'h0);
        chk("arst_busy", {63'h0, net_busy}, 64'h0);
        chk("arst_cnt", {48'h0, frame_cnt}, 64'h0);
        chk("arst_first", {63'h0, first}, 64'h0);
        chk("arst_err", {63'h0, err_len}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_err", {63'h0, err_len}, 64'h0);
        beat(8'd0, 1'b0);
        beat(8'd255, 1'b0);
        beat(8'd128, 1'b0);
        beat(8'd1, 1'b1);
        @(negedge clk);
        chk("post_rst_first", {63'h0, first}, 64'h1);
        chk("post_rst_vec", in_vec, frame1_vec);
        chk("post_rst_cnt", {48'h0, frame_cnt}, 64'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/nn_input_loader.md
Name: nn_input_loader

Overview:
- Stage directly upstream of the neural network top; produces its packed input vector and its one-cycle `first` launch pulse.
- Accepts a valid/ready pixel stream and converts each unsigned pixel to the network's fixed-point format.
- Packs one frame of NUM_INPUTS values into a shadow buffer, then launches the frame only when the network is idle.
- Can fill the next frame while the network is still processing the current one.

Parameters:
- NUM_INPUTS, 4, values per frame (equals layer-0 width of the network).
- DATA_WIDTH, 16, fixed-point word width per value.
- FRAC_BITS, 11, fractional bits of the fixed-point format.
- PIXEL_WIDTH, 8, width of incoming unsigned pixels.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  pixel beat valid.
- s_ready  out  1  loader can accept a beat.
- s_data  in  PIXEL_WIDTH  unsigned pixel.
- s_last  in  1  marks final beat of a frame.
- net_done  in  1  one-cycle pulse from the network's final stage: result valid, network idle.
- in_vec  out  NUM_INPUTS*DATA_WIDTH  packed frame to the network input.
- first  out  1  one-cycle launch pulse to the network.
- net_busy  out  1  a launched frame is in flight.
- err_len  out  1  one-cycle pulse when a short frame is discarded.
- frame_cnt  out  16  count of frames launched, wraps at 2^16.

Behaviour:
- Reset (async, rst_n=0): state=FILL, beat count=0, shadow buffer=0, in_vec=0, first=0, net_busy=0, err_len=0, frame_cnt=0. s_ready=1 after reset release.
- Conversion (per beat, combinational before the shadow write):
  - If FRAC_BITS>=PIXEL_WIDTH: q = s_data << (FRAC_BITS-PIXEL_WIDTH); otherwise q = s_data >> (PIXEL_WIDTH-FRAC_BITS).
  - Zero-extend q to DATA_WIDTH. Defaults give 255 -> 0x07F8.
- Packing: the k-th accepted beat of a frame (k from 0) is written to shadow bits [k*DATA_WIDTH +: DATA_WIDTH].
- FSM, two states:
  - FILL: s_ready=1. A beat is accepted when s_valid&&s_ready.
    - Beat k==NUM_INPUTS-1 accepted -> FULL. s_last on this beat is ignored.
    - s_last on a beat with k<NUM_INPUTS-1 -> discard frame, count=0, err_len=1 next cycle, stay FILL.
  - FULL: s_ready=0. Launch condition: net_busy==0 || net_done.
    - At the launching edge: in_vec<=shadow, first<=1 for exactly one cycle, net_busy<=1, frame_cnt<=frame_cnt+1, count<=0, state->FILL.
- net_busy:
  - Set on launch; cleared on net_done when there is no simultaneous launch.
  - net_done and launch in the same cycle: net_busy stays 1 (back-to-back frames).
  - net_done while net_busy==0 is ignored.
- Latency: final beat accepted at edge N; with the network idle, first=1 and the new in_vec are visible in the cycle after edge N+1.
- in_vec is held stable from one launch to the next. It never changes while net_busy=1 except at a launch coinciding with net_done.
- Back-pressure: s_ready is registered-state driven only, never combinationally dependent on s_valid.
- s_valid may drop mid-frame without penalty; the partial frame is retained.
- Reset mid-frame or mid-flight: all state is lost, and no first or err_len pulse is generated.

Optional Feature:
- Macro NN_IN_CENTER_EN.
- Defined: the converted value is centred before packing, q_c = q - (2^PIXEL_WIDTH-1 shifted as in the conversion)/2, truncated toward zero. The result is a signed two's-complement value sign-extended to DATA_WIDTH. Example: 0 -> 0xFC04, 255 -> 0x03FC, 128 -> 0x0004.
- Undefined: unsigned zero-extended conversion only, and no subtractor is present in the RTL.

Decomposition:
- Shared package nn_pkg:
  - Localparam defaults for DATA_WIDTH and FRAC_BITS.
  - Typedef fx_t (logic [DATA_WIDTH-1:0]).
  - Enum loader_state_t {FILL, FULL}.
  - Function pixel_to_fx implementing the shift and the optional centring.
- Sub-module nn_pixel_quant: purely combinational conversion, parameterised by PIXEL_WIDTH, FRAC_BITS and DATA_WIDTH. Instantiated once.

Test Plan:
- Reset then idle network, stream pixels 0, 255, 128, 1 (s_last on 4th) -> one first pulse. in_vec = {0x0008, 0x0400, 0x07F8, 0x0000} (element 3..0), net_busy=1, frame_cnt=1.
- While net_busy=1, stream a second frame -> s_ready drops after 4 beats, no first pulse. Then pulse net_done -> first pulses on the following cycle, in_vec updates, net_busy stays 1, frame_cnt=2.
- s_last on 2nd beat -> err_len pulses once, s_ready stays 1, no first. The next 4 beats form a clean frame with element 0 = 1st new beat.
- s_valid toggling 1,0,0,1,1,0,1 -> exactly 4 beats captured in order, launch timing measured from the 4th handshake = 2 edges.
- Assert rst_n=0 asynchronously mid-frame (2 beats in) and mid-flight -> all outputs 0 immediately, and the next full frame launches normally with frame_cnt=1.
- With NN_IN_CENTER_EN: pixels 0, 255 -> elements 0xFC04, 0x03FC.
